// File: rtl/rx_receiver.sv
// Serial frame receiver: recovers a start/data/stop framed packet from a single
// wire, checks its CRC-16-CCITT and flags framing errors.
module rx_receiver #(
  parameter int unsigned CLKS_PER_BIT = 50,
  parameter int unsigned PACKET_W     = 136
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_line,
  output logic [PACKET_W-1:0] rx_packet,
  output logic                rx_valid,
  output logic                crc_ok,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE,
    WAIT_HIGH
  } state_t;

  state_t              state;
  logic                sync_ff;
  logic                s_line;
  logic [CNT_W-1:0]    baud_cnt;
  logic [7:0]          bit_cnt;
  logic [15:0]         crc;
  logic [PACKET_W-1:0] shift_reg;

  // One serial step of CRC-16-CCITT (poly 0x1021, MSB first)
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff   <= 1'b1;
      s_line    <= 1'b1;
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      crc       <= 16'hFFFF;
      shift_reg <= '0;
      rx_packet <= '0;
      rx_valid  <= 1'b0;
      crc_ok    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync_ff   <= rx_line;
      s_line    <= sync_ff;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // The detection cycle counts as the first cycle of the half-bit wait
          if (!s_line) begin
            state    <= START;
            baud_cnt <= CNT_W'(1);
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == CNT_W'(HALF - 1)) begin
            baud_cnt <= '0;
            if (!s_line) begin
              state   <= DATA;
              bit_cnt <= '0;
              crc     <= 16'hFFFF;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            baud_cnt  <= '0;
            shift_reg <= {shift_reg[PACKET_W-2:0], s_line};
            crc       <= crc_step(crc, s_line);
            if (bit_cnt == 8'(PACKET_W - 1)) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            if (s_line) begin
              state <= DONE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          rx_packet <= shift_reg;
          crc_ok    <= (crc == 16'h0000);
          rx_valid  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        WAIT_HIGH: begin
          // Hold off until the line recovers so a stuck-low line cannot retrigger
          if (s_line) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_receiver.sv
// Scoreboard bench for rx_receiver: stimulus pushes expected frames and error
// pulses with their arrival cycles; a monitor branch pops and compares them.
module tb_rx_receiver;

  localparam int unsigned CPB  = 8;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned W    = 136;

  typedef struct {
    logic [W-1:0] pkt;
    logic         ok;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_line;
  logic [W-1:0] rx_packet;
  logic         rx_valid;
  logic         crc_ok;
  logic         frame_err;
  logic         busy;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  exp_t vq[$];
  int   fq[$];
  exp_t e;
  int   fe_cyc;
  bit   prev_v = 1'b0;
  bit   prev_fe = 1'b0;
  int   last_valid_cyc = 0;
  int   prev_valid_cyc = 0;
  bit   saw_busy;

  logic [119:0] pay1;
  logic [119:0] pay3;
  logic [W-1:0] f1;
  logic [W-1:0] f_bad;
  logic [W-1:0] f3;

  rx_receiver #(.CLKS_PER_BIT(CPB), .PACKET_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_line   (rx_line),
    .rx_packet (rx_packet),
    .rx_valid  (rx_valid),
    .crc_ok    (crc_ok),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] crc16(input logic [119:0] p);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 119; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ p[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Caller is at a negedge; sends start, nbits data bits MSB first, then stop if complete
  task automatic send_frame(input logic [W-1:0] f, input logic stop_v, input int nbits,
                            input logic exp_ok);
    exp_t x;
    if (nbits == int'(W)) begin
      if (stop_v) begin
        x.pkt = f;
        x.ok  = exp_ok;
        x.cyc = cyc + 3 + int'(HALF) + 137 * int'(CPB);
        vq.push_back(x);
      end else begin
        fq.push_back(cyc + 2 + int'(HALF) + 137 * int'(CPB));
      end
    end
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_line = f[W-1-i];
      repeat (CPB) @(negedge clk);
    end
    if (nbits == int'(W)) begin
      rx_line = stop_v;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    pay1  = 120'h0123456789ABCDEF0123456789ABCD;
    pay3  = 120'hFEDCBA9876543210FEDCBA98765432;
    f1    = {pay1, crc16(pay1)};
    f3    = {pay3, crc16(pay3)};
    f_bad = f1;
    f_bad[80] = ~f_bad[80];

    rst     = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    chk(rx_packet == '0, "reset_rx_packet", rx_packet, '0);
    chk(!crc_ok,    "reset_crc_ok",    W'(crc_ok),    '0);
    chk(!rx_valid,  "reset_rx_valid",  W'(rx_valid),  '0);
    chk(!frame_err, "reset_frame_err", W'(frame_err), '0);
    chk(!busy,      "reset_busy",      W'(busy),      '0);
    rst = 1'b0;
    idle(2 * CPB);

    fork
      begin : stim
        // Good frame, then same frame with payload bit 64 flipped
        send_frame(f1, 1'b1, W, 1'b1);
        idle(2 * CPB);
        send_frame(f_bad, 1'b1, W, 1'b0);
        idle(2 * CPB);

        // Two-cycle low glitch is rejected at the start-bit mid-sample
        saw_busy = 1'b0;
        rx_line  = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 1) rx_line = 1'b1;
          if (busy) saw_busy = 1'b1;
        end
        chk(saw_busy, "glitch_start_seen", W'(saw_busy), W'(1));
        chk(!busy, "glitch_busy_cleared", W'(busy), '0);
        idle(2 * CPB);

        // Good frame, then bad stop bit with the line held low afterwards
        send_frame(f1, 1'b1, W, 1'b1);
        send_frame(f_bad, 1'b0, W, 1'b0);
        rx_line = 1'b0;
        repeat (20) @(negedge clk);
        chk(busy, "wait_high_busy", W'(busy), W'(1));
        idle(2 * CPB);
        chk(!busy, "wait_high_released", W'(busy), '0);
        chk(rx_packet == f1, "err_keeps_packet", rx_packet, f1);
        chk(crc_ok, "err_keeps_crc_ok", W'(crc_ok), W'(1));

        // Reset at data bit 70 discards the frame; next frame still received
        send_frame(f1, 1'b1, 70, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk(rx_packet == '0, "midrst_rx_packet", rx_packet, '0);
        chk(!crc_ok,    "midrst_crc_ok",    W'(crc_ok),    '0);
        chk(!rx_valid,  "midrst_rx_valid",  W'(rx_valid),  '0);
        chk(!frame_err, "midrst_frame_err", W'(frame_err), '0);
        chk(!busy,      "midrst_busy",      W'(busy),      '0);
        rst = 1'b0;
        idle(3 * CPB);
        send_frame(f1, 1'b1, W, 1'b1);
        idle(2 * CPB);

        // Back-to-back frames with no idle bits between them
        send_frame(f1, 1'b1, W, 1'b1);
        send_frame(f3, 1'b1, W, 1'b1);
        idle(3 * CPB);
        chk(last_valid_cyc - prev_valid_cyc == 138 * int'(CPB), "b2b_spacing",
            W'(last_valid_cyc - prev_valid_cyc), W'(138 * CPB));
        done = 1'b1;
      end
      begin : mon
        while (!done) begin
          @(negedge clk);
          if (rx_valid || frame_err) begin
            chk(!(rx_valid && frame_err), "valid_err_exclusive",
                W'({rx_valid, frame_err}), W'(0));
            chk(!(rx_valid && prev_v) && !(frame_err && prev_fe), "single_cycle_pulse",
                W'({prev_v, rx_valid, prev_fe, frame_err}), W'(0));
          end
          if (rx_valid) begin
            if (vq.size() == 0) begin
              chk(1'b0, "unexpected_rx_valid", W'(cyc), '0);
            end else begin
              e = vq.pop_front();
              chk(rx_packet == e.pkt, "rx_packet", rx_packet, e.pkt);
              chk(crc_ok == e.ok, "crc_ok", W'(crc_ok), W'(e.ok));
              chk(cyc == e.cyc, "rx_valid_cycle", W'(cyc), W'(e.cyc));
              chk(!busy, "busy_low_at_valid", W'(busy), '0);
              prev_valid_cyc = last_valid_cyc;
              last_valid_cyc = cyc;
            end
          end
          if (frame_err) begin
            if (fq.size() == 0) begin
              chk(1'b0, "unexpected_frame_err", W'(cyc), '0);
            end else begin
              fe_cyc = fq.pop_front();
              chk(cyc == fe_cyc, "frame_err_cycle", W'(cyc), W'(fe_cyc));
            end
          end
          prev_v  = rx_valid;
          prev_fe = frame_err;
        end
      end
    join

    chk(vq.size() == 0, "missing_rx_valid", W'(vq.size()), '0);
    chk(fq.size() == 0, "missing_frame_err", W'(fq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
